// File: rtl/if_id_fetch_queue_if.sv
// Fetch/decode-side bundle for the IF/ID fetch queue.
// The master side is the fetch and decode stages; the slave side is the queue.
interface if_id_fetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              push;
    logic [DATA_W-1:0] instruction;
    logic [DATA_W-1:0] pcResult;
    logic [DATA_W-1:0] pcAdderOut;
    logic              flush;
    logic              idStall;

    logic              full;
    logic [CNT_W-1:0]  count;
    logic              outValid;
    logic [DATA_W-1:0] idInstruction;
    logic [DATA_W-1:0] idPc;
    logic [DATA_W-1:0] idPcPlus4;
    logic              overflow;

    modport master (
        output push, instruction, pcResult, pcAdderOut, flush, idStall,
        input  full, count, outValid, idInstruction, idPc, idPcPlus4, overflow
    );

    modport slave (
        input  push, instruction, pcResult, pcAdderOut, flush, idStall,
        output full, count, outValid, idInstruction, idPc, idPcPlus4, overflow
    );
endinterface

// File: rtl/if_id_fetch_queue.sv
// IF/ID decoupling queue: a DEPTH-entry circular FIFO feeding a registered
// output stage for decode, with flush on redirect and sticky overflow.
module if_id_fetch_queue #(
    parameter int                DEPTH  = 4,
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] NOP    = '0
) (
    input logic               clk_i,
    input logic               rst_i,
    if_id_fetch_queue_if.slave q
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pcPlus4;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             outValid_q, outValid_d;
    entry_t           out_q, out_d;
    logic             overflow_q, overflow_d;

    logic             load;
    logic             empty;
    logic             full;
    logic             wrEn;
    entry_t           inEntry;

    // Count is kept alongside the pointers so full/empty never alias.
    always_comb begin
        inEntry    = '{instr: q.instruction, pc: q.pcResult, pcPlus4: q.pcAdderOut};
        full       = (count_q == FULL_CNT);
        empty      = (count_q == '0);
        load       = ~outValid_q | ~q.idStall;

        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        count_d    = count_q;
        outValid_d = outValid_q;
        out_d      = out_q;
        overflow_d = overflow_q;
        wrEn       = 1'b0;

        if (q.flush) begin
            // A push alongside a flush is wrong-path and is simply discarded.
            rdPtr_d     = '0;
            wrPtr_d     = '0;
            count_d     = '0;
            outValid_d  = 1'b0;
            out_d.instr = NOP;
        end else if (load && !empty) begin
            out_d      = mem_q[rdPtr_q];
            outValid_d = 1'b1;
            rdPtr_d    = rdPtr_q + PTR_W'(1);
            if (q.push) begin
                wrEn    = 1'b1;
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end else if (load && q.push) begin
            out_d      = inEntry;
            outValid_d = 1'b1;
        end else if (load) begin
            outValid_d  = 1'b0;
            out_d.instr = NOP;
        end else if (q.push) begin
            if (!full) begin
                wrEn    = 1'b1;
                wrPtr_d = wrPtr_q + PTR_W'(1);
                count_d = count_q + CNT_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            outValid_q <= 1'b0;
            out_q      <= '{instr: NOP, pc: '0, pcPlus4: '0};
            overflow_q <= 1'b0;
        end else begin
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            outValid_q <= outValid_d;
            out_q      <= out_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset; only pointers and count matter.
    always_ff @(posedge clk_i) begin
        if (wrEn) begin
            mem_q[wrPtr_q] <= inEntry;
        end
    end

    assign q.full          = full;
    assign q.count         = count_q;
    assign q.outValid      = outValid_q;
    assign q.idInstruction = out_q.instr;
    assign q.idPc          = out_q.pc;
    assign q.idPcPlus4     = out_q.pcPlus4;
    assign q.overflow      = overflow_q;
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Bench for if_id_fetch_queue: directed scenarios plus random traffic, all
// compared every cycle against a queue-based model of the decode-side view.
module tb_if_id_fetch_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    ent_t        mq[$];
    logic        mValid;
    ent_t        mOut;
    logic        mOverflow;
    logic        collect = 1'b0;
    logic [31:0] accepted[$];

    if_id_fetch_queue_if #(.DEPTH(DEPTH), .DATA_W(32)) bus ();

    if_id_fetch_queue #(.DEPTH(DEPTH), .DATA_W(32), .NOP(32'h0)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .q     (bus)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mValid    = 1'b0;
        mOut      = '{instr: 32'h0, pc: 32'h0, pc4: 32'h0};
        mOverflow = 1'b0;
    endtask

    // What decode should see after one edge, from the queue's stated rules.
    task automatic modelStep(input logic push, input ent_t e, input logic flush, input logic stall);
        if (flush) begin
            mq.delete();
            mValid     = 1'b0;
            mOut.instr = 32'h0;
        end else if (!mValid || !stall) begin
            if (mq.size() > 0) begin
                mOut   = mq.pop_front();
                mValid = 1'b1;
                if (push) mq.push_back(e);
            end else if (push) begin
                mOut   = e;
                mValid = 1'b1;
            end else begin
                mValid     = 1'b0;
                mOut.instr = 32'h0;
            end
        end else if (push) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else mOverflow = 1'b1;
        end
    endtask

    task automatic checkOutput();
        checkVal("count",    32'(bus.count),        32'(mq.size()));
        checkVal("full",     32'(bus.full),         32'(mq.size() == DEPTH));
        checkVal("outValid", 32'(bus.outValid),     32'(mValid));
        checkVal("idInstr",  bus.idInstruction,     mOut.instr);
        checkVal("idPc",     bus.idPc,              mOut.pc);
        checkVal("idPc4",    bus.idPcPlus4,         mOut.pc4);
        checkVal("overflow", 32'(bus.overflow),     32'(mOverflow));
    endtask

    task automatic applyStimulus(input logic push, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic flush, input logic stall);
        ent_t e;
        e = '{instr: instr, pc: pc, pc4: pc + 32'd4};
        bus.push        = push;
        bus.instruction = instr;
        bus.pcResult    = pc;
        bus.pcAdderOut  = pc + 32'd4;
        bus.flush       = flush;
        bus.idStall     = stall;
        if (collect && bus.outValid && !stall) accepted.push_back(bus.idInstruction);
        @(posedge clk);
        modelStep(push, e, flush, stall);
        #1;
        checkOutput();
    endtask

    task automatic resetDut();
        rst             = 1'b1;
        bus.push        = 1'b0;
        bus.instruction = 32'h0;
        bus.pcResult    = 32'h0;
        bus.pcAdderOut  = 32'h0;
        bus.flush       = 1'b0;
        bus.idStall     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        checkOutput();
    endtask

    initial begin
        logic [31:0] pc;
        int          n;
        int          guard;

        // Reset state, pinned with literals.
        resetDut();
        checkVal("rstCount", 32'(bus.count), 32'd0);
        checkVal("rstValid", 32'(bus.outValid), 32'd0);
        checkVal("rstInstr", bus.idInstruction, 32'h0);
        checkVal("rstPc", bus.idPc, 32'h0);

        // Six back-to-back pushes bypass straight to decode.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 32'h11 + 32'(i), 32'(4 * i), 1'b0, 1'b0);
            checkVal("bypassInstr", bus.idInstruction, 32'h11 + 32'(i));
        end
        checkVal("bypassPc", bus.idPc, 32'h14);
        checkVal("bypassPc4", bus.idPcPlus4, 32'h18);
        checkVal("bypassCount", 32'(bus.count), 32'd0);

        // Fill under stall, then one push too many.
        resetDut();
        applyStimulus(1'b1, 32'h11, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h12 + 32'(i), 32'(4 * (i + 1)), 1'b0, 1'b1);
            checkVal("fillCount", 32'(bus.count), 32'(i + 1));
        end
        checkVal("fillFull", 32'(bus.full), 32'd1);
        applyStimulus(1'b1, 32'h16, 32'h14, 1'b0, 1'b1);
        checkVal("ovfFlag", 32'(bus.overflow), 32'd1);
        checkVal("ovfCount", 32'(bus.count), 32'd4);
        checkVal("ovfHold", bus.idInstruction, 32'h11);

        // Drain from full while pushing every cycle, then stop pushing.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 32'h20 + 32'(i), 32'h80 + 32'(4 * i), 1'b0, 1'b0);
            if (i == 0) checkVal("drainFirst", bus.idInstruction, 32'h12);
            checkVal("drainCount", 32'(bus.count), 32'd4);
        end
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkVal("drainValid", 32'(bus.outValid), 32'd0);
        checkVal("drainNop", bus.idInstruction, 32'h0);

        // Flush with three queued entries and a wrong-path push.
        applyStimulus(1'b1, 32'h30, 32'hC0, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) applyStimulus(1'b1, 32'h30 + 32'(i), 32'hC0 + 32'(4 * i), 1'b0, 1'b1);
        checkVal("preFlushCount", 32'(bus.count), 32'd3);
        applyStimulus(1'b1, 32'h34, 32'hD0, 1'b1, 1'b1);
        checkVal("flushCount", 32'(bus.count), 32'd0);
        checkVal("flushValid", 32'(bus.outValid), 32'd0);
        checkVal("flushNop", bus.idInstruction, 32'h0);
        checkVal("flushPcHold", bus.idPc, 32'hC0);
        applyStimulus(1'b1, 32'h40, 32'h100, 1'b0, 1'b0);
        checkVal("postFlushInstr", bus.idInstruction, 32'h40);
        checkVal("postFlushPc", bus.idPc, 32'h100);

        // Wrap-around: stall toggles, fetch obeys back-pressure, order recorded.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        collect = 1'b1;
        n       = 0;
        guard   = 0;
        while (n < 20 && guard < 200) begin
            logic p;
            p = (mq.size() < DEPTH);
            applyStimulus(p, 32'h50 + 32'(n), 32'h400 + 32'(4 * n), 1'b0, guard[0]);
            if (p) n++;
            guard++;
        end
        checkVal("wrapPushes", 32'(n), 32'd20);
        repeat (8) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        collect = 1'b0;
        checkVal("wrapCount", 32'(accepted.size()), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (i < accepted.size()) checkVal("wrapOrder", accepted[i], 32'h50 + 32'(i));
        end

        // Random traffic including overflow and flushes.
        resetDut();
        pc = 32'h1000;
        for (int i = 0; i < 1500; i++) begin
            logic fl, pu, st;
            fl = ($urandom_range(0, 19) == 0);
            pu = ($urandom_range(0, 9) < 7);
            st = ($urandom_range(0, 9) < 4);
            applyStimulus(pu, $urandom, pc, fl, st);
            if (fl) pc = {$urandom_range(0, 32'hFFFF), 2'b00};
            else if (pu) pc = pc + 32'd4;
        end

        // Asynchronous reset between edges with two entries queued.
        resetDut();
        applyStimulus(1'b1, 32'h70, 32'h180, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h71, 32'h184, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h72, 32'h188, 1'b0, 1'b1);
        checkVal("preRstCount", 32'(bus.count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        checkVal("asyncCount", 32'(bus.count), 32'd0);
        checkVal("asyncValid", 32'(bus.outValid), 32'd0);
        checkVal("asyncInstr", bus.idInstruction, 32'h0);
        checkVal("asyncPc", bus.idPc, 32'h0);
        checkVal("asyncPc4", bus.idPcPlus4, 32'h0);
        modelReset();
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 32'h80, 32'h200, 1'b0, 1'b0);
        checkVal("postRstInstr", bus.idInstruction, 32'h80);
        checkVal("postRstValid", 32'(bus.outValid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
Decoupling buffer and IF/ID pipeline register between the instruction-fetch stage and the decode stage.
- Captures each fetched instruction together with its PC and PC+4.
- Buffers up to DEPTH entries while decode is stalled.
- Presents one registered entry per cycle to ID.
- Discards all in-flight fetches when a taken branch or jump redirects the PC.
- Full drives fetch back-pressure: the fetch stage's PCWrite = ~Full.

Parameters:
DEPTH, 4, number of queue entries; must be a power of 2, minimum 2
DATA_W, 32, width of instruction and address fields
NOP, 32'h00000000, instruction value driven on ID_Instruction when no valid entry is held

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Push  in  1  fetch stage has a valid instruction this cycle
Instruction  in  DATA_W  fetched instruction word
PCResult  in  DATA_W  PC of the fetched instruction
PCAdder_Out  in  DATA_W  PC+4 of the fetched instruction
Flush  in  1  taken branch or jump resolved (BranchFlagID | JumpControl); discards all held entries
IDStall  in  1  decode cannot accept a new entry this cycle
Full  out  1  queue holds DEPTH entries; combinational from Count
Count  out  clog2(DEPTH+1)  number of queued entries, excluding the output register
OutValid  out  1  ID_* outputs hold a valid instruction
ID_Instruction  out  DATA_W  instruction presented to decode
ID_PC  out  DATA_W  PC presented to decode
ID_PCPlus4  out  DATA_W  PC+4 presented to decode
Overflow  out  1  sticky error: a push was dropped while Full with no pop in the same cycle

Behaviour:
- Reset (asynchronous, active-high, immediate):
  - Count=0, read/write pointers=0, OutValid=0, Overflow=0.
  - ID_Instruction=NOP, ID_PC=0, ID_PCPlus4=0.
  - Queue storage is not cleared.
  - Reset asserted mid-operation drops everything, including the output register.
- Storage: DEPTH-entry circular FIFO of {Instruction, PCResult, PCAdder_Out}.
  - Pointers wrap modulo DEPTH.
  - Count is tracked separately, so full and empty are unambiguous.
- Load enable: load = ~OutValid | ~IDStall, evaluated each rising edge.
- Priority at each rising edge, highest first:
  1. Flush=1:
     - Count<=0, pointers<=0, OutValid<=0, ID_Instruction<=NOP.
     - ID_PC and ID_PCPlus4 hold their values.
     - Push in the same cycle is dropped. It is the wrong-path instruction and is not flagged as Overflow.
  2. load=1 and Count>0:
     - Output register <= head entry; OutValid<=1; read pointer advances.
     - If Push also: write at the write pointer; Count unchanged. This is allowed even when Full, because the pop frees the slot.
     - Otherwise Count decrements.
  3. load=1, Count=0, Push=1 (bypass):
     - Output register <= input fields directly; OutValid<=1.
     - Latency is 1 edge from push to ID outputs.
  4. load=1, Count=0, Push=0:
     - OutValid<=0; ID_Instruction<=NOP (bubble).
     - ID_PC and ID_PCPlus4 hold their values.
  5. load=0 (OutValid=1 and IDStall=1):
     - Output register holds.
     - Push with Count<DEPTH: write entry, Count increments.
     - Push with Count=DEPTH: entry dropped, Overflow<=1. Overflow stays set until Reset.
- Ordering: entries reach ID strictly in push order; no entry is duplicated or skipped.
- Full = (Count==DEPTH). No combinational path from Push, Flush or IDStall to Full or OutValid.
- Minimum latency is 1 cycle (bypass). Queued entries leave 1 per cycle once IDStall deasserts.

Test Plan:
- Reset then 6 consecutive pushes, IDStall=0:
  - Instructions 0x11..0x16 with PC 0x0,0x4,... appear on ID one edge after each push.
  - OutValid stays 1; Count stays 0.
- Fill under stall:
  - OutValid=1 holding 0x11, IDStall=1, push 0x12..0x15 -> Count 1,2,3,4; Full=1 after the 4th.
  - A 5th push 0x16 with Full=1 and IDStall=1 -> dropped, Overflow=1, Count=4.
- Drain with concurrent push:
  - From Full, IDStall=0 and a push every cycle -> ID sequence 0x12,0x13,0x14,0x15,new...; Count stays 4; no Overflow.
  - Stop pushing -> Count decrements to 0, then OutValid=0 and ID_Instruction=NOP.
- Flush with Count=3 and a simultaneous push -> next cycle Count=0, OutValid=0, ID_Instruction=NOP, pushed entry absent.
  - Following push of 0x40 (PC 0x100) appears on ID one edge later.
- Pointer wrap-around: with IDStall toggling every other cycle, push 20 sequential instructions -> ID receives all 20 in order, no duplicates.
- Asynchronous reset asserted between clock edges with Count=2, OutValid=1:
  - Outputs go to reset values immediately, before the next edge.
  - After release, the first push bypasses to ID.
